mem_2p_ctrl: RTL

MEM_2P_CTRL -- requirements
Module: mem_2p_ctrl

---
 rtl/mem_2p_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_2p_ctrl.sv
// ---------------------------------------------------------------------------
// mem_2p_ctrl: two-port (1W + 1R) word memory controller with clear sweep.
//
// A single-clock array of 2**PSIZE words of WIDTH bits.
// - Writes are bit-masked.
// - Reads are fully pipelined with a latency of RD_LAT (1 or 2) cycles.
// - A clear sweep zeroes the array one word per cycle. It runs after reset
//   and on request.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_wr       write request
//   in_wr_addr  write address
//   in_data     write data
//   in_wr_mask  per-bit write enable (1 = bit written)
//   in_rd       read request
//   in_rd_addr  read address
//   in_clr      request a clear sweep of the whole array
//   out_data    read data (holds while out_valid = 0)
//   out_valid   out_data carries a completed read this cycle
//   out_busy    clear sweep in progress; requests are ignored
//
// Optional feature (macro MEM_2P_BYPASS_EN):
//   When defined, a same-cycle same-address read returns the post-write
//   merged word. When undefined, such a read returns the pre-write contents.
// ---------------------------------------------------------------------------
module mem_2p_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PSIZE  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_wr,
  input  logic [PSIZE-1:0] in_wr_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_wr_mask,
  input  logic             in_rd,
  input  logic [PSIZE-1:0] in_rd_addr,
  input  logic             in_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_busy
);

  localparam int unsigned DEPTH = 2 ** PSIZE;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PSIZE-1:0] cnt_q;
  logic [PSIZE-1:0] cnt_d;
  logic             busy_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_fire;
  logic             rd_fire;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_word;
  logic             mem_we;
  logic [PSIZE-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             s0_vld;
  logic [WIDTH-1:0] s0_dat;

  // State register: reset lands in a sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // Next state: the sweep walks every address once, then returns to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == PSIZE'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PSIZE'(1);
        end
      end
      ST_IDLE: begin
        if (in_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath control: the clear request wins over same-cycle requests.
  always_comb begin
    wr_fire   = (state_q == ST_IDLE) && !in_clr && in_wr;
    rd_fire   = (state_q == ST_IDLE) && !in_clr && in_rd;
    wr_merged = (in_data & in_wr_mask) | (mem[in_wr_addr] & ~in_wr_mask);

    mem_we    = wr_fire;
    mem_waddr = in_wr_addr;
    mem_wdata = wr_merged;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end

    rd_word = mem[in_rd_addr];
`ifdef MEM_2P_BYPASS_EN
    // Forward the merged write word to a colliding read.
    if (wr_fire && (in_wr_addr == in_rd_addr)) begin
      rd_word = wr_merged;
    end
`endif
  end

  assign out_busy = busy_q;

  // Storage array: not reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // First read stage: data is captured at launch and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
      s0_dat <= '0;
    end else begin
      s0_vld <= rd_fire;
      if (rd_fire) begin
        s0_dat <= rd_word;
      end
    end
  end

  // Optional second read stage: it only advances when carrying a read, so
  // the output data holds between reads.
  if (RD_LAT == 2) begin : g_lat2
    logic             s1_vld;
    logic [WIDTH-1:0] s1_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld <= 1'b0;
        s1_dat <= '0;
      end else begin
        s1_vld <= s0_vld;
        if (s0_vld) begin
          s1_dat <= s0_dat;
        end
      end
    end

    assign out_valid = s1_vld;
    assign out_data  = s1_dat;
  end else begin : g_lat1
    assign out_valid = s0_vld;
    assign out_data  = s0_dat;
  end

endmodule
